// File: rtl/zzseq.sv
// Job sequencer for the bit-serial matrix-vector unit: walks tiles and zig-zag
// bit-plane pairs, turning zig-zag offsets into absolute weight/data plane addresses.
module zzseq #(
   parameter int unsigned BWADDR = 21,
   parameter int unsigned BPREC  = 4,
   parameter int unsigned BCNT   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [BPREC-1:0]  pw,
   input  logic [BPREC-1:0]  pd,
   input  logic [BWADDR-1:0] wbase,
   input  logic [BWADDR-1:0] dbase,
   input  logic [BCNT-1:0]   ntiles,
   output logic              busy,
   output logic              done,
   output logic              step,
   output logic              clr,
   input  logic [BPREC-1:0]  offw,
   input  logic [BPREC-1:0]  offd,
   input  logic              sh,
   output logic              addr_vld,
   input  logic              addr_rdy,
   output logic [BWADDR-1:0] waddr,
   output logic [BWADDR-1:0] daddr,
   output logic              diag,
   output logic              tlast,
   output logic              jlast
);

   localparam int unsigned BPAIR = 2 * BPREC;
   localparam logic [BPAIR-1:0] PONE = BPAIR'(1);
   localparam logic [BCNT-1:0]  TONE = BCNT'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [BPREC-1:0]  pw_r, pd_r;
   logic [BWADDR-1:0] wbase_r, dbase_r;
   logic [BWADDR-1:0] wtile, dtile;
   logic [BCNT-1:0]   ntiles_r, tcnt;
   logic [BPAIR-1:0]  prod_r, pcnt;
   logic              hold;
   logic              busy_r, done_r, vld_r;
   logic              accept;
   logic [BPAIR-1:0]  prod_next;

   assign prod_next = BPAIR'(pw) * BPAIR'(pd);
   assign accept    = vld_r & addr_rdy;

   assign step     = accept;
   assign clr      = (state != RUN);
   assign busy     = busy_r;
   assign done     = done_r;
   assign addr_vld = vld_r;

   // Gated by vld so a stale pcnt/prod after a job never shows up as tlast in IDLE.
   assign tlast = vld_r & (pcnt == prod_r - PONE);
   assign jlast = tlast & (tcnt == ntiles_r - TONE);
   // hold covers the cycles where the zig-zag unit has already dropped sh during a stall.
   assign diag  = (pcnt == '0) | sh | hold;

   assign waddr = wbase_r + wtile + BWADDR'(offw);
   assign daddr = dbase_r + dtile + BWADDR'(offd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pw_r     <= '0;
         pd_r     <= '0;
         wbase_r  <= '0;
         dbase_r  <= '0;
         ntiles_r <= '0;
         prod_r   <= '0;
         pcnt     <= '0;
         tcnt     <= '0;
         wtile    <= '0;
         dtile    <= '0;
         hold     <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         vld_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  pw_r     <= pw;
                  pd_r     <= pd;
                  wbase_r  <= wbase;
                  dbase_r  <= dbase;
                  ntiles_r <= ntiles;
                  prod_r   <= prod_next;
                  pcnt     <= '0;
                  tcnt     <= '0;
                  wtile    <= '0;
                  dtile    <= '0;
                  hold     <= 1'b0;
                  if (ntiles == '0 || pw == '0 || pd == '0) begin
                     state  <= DONE;
                     done_r <= 1'b1;
                  end else begin
                     state  <= RUN;
                     busy_r <= 1'b1;
                     vld_r  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  hold <= 1'b0;
                  if (tlast) begin
                     pcnt  <= '0;
                     tcnt  <= tcnt + TONE;
                     wtile <= wtile + BWADDR'(pw_r);
                     dtile <= dtile + BWADDR'(pd_r);
                     if (jlast) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        vld_r  <= 1'b0;
                        done_r <= 1'b1;
                     end
                  end else begin
                     pcnt <= pcnt + PONE;
                  end
               end else if (sh) begin
                  hold <= 1'b1;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               vld_r  <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zzseq.sv
// Bench for zzseq: behavioural zig-zag unit upstream, scoreboard of expected
// address pairs checked as the sequencer presents them.
module tb_zzseq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  pw, pd;
   logic [20:0] wbase, dbase;
   logic [15:0] ntiles;
   logic        busy, done, step, clr;
   logic [3:0]  offw, offd;
   logic        sh;
   logic        addr_vld, addr_rdy;
   logic [20:0] waddr, daddr;
   logic        diag, tlast, jlast;

   typedef struct {
      logic [20:0] w;
      logic [20:0] d;
      logic        dg;
      logic        tl;
      logic        jl;
   } pair_t;

   pair_t q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    c0 = 0;
   int    n_pairs = 0;
   int    m_pw = 0;
   int    m_pd = 0;

   zzseq #(.BWADDR(21), .BPREC(4), .BCNT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pw(pw), .pd(pd), .wbase(wbase), .dbase(dbase), .ntiles(ntiles),
      .busy(busy), .done(done), .step(step), .clr(clr),
      .offw(offw), .offd(offd), .sh(sh),
      .addr_vld(addr_vld), .addr_rdy(addr_rdy),
      .waddr(waddr), .daddr(daddr), .diag(diag), .tlast(tlast), .jlast(jlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Zig-zag unit: diagonals of increasing w+d, w descending within a diagonal,
   // sh only on the cycle after a step that lands on a new diagonal.
   always @(posedge clk) begin
      int s, nw, nd;
      if (clr) begin
         offw <= '0; offd <= '0; sh <= 1'b0;
      end else if (step) begin
         if (int'(offw) > 0 && int'(offd) < m_pd - 1) begin
            offw <= offw - 4'd1; offd <= offd + 4'd1; sh <= 1'b0;
         end else begin
            s = int'(offw) + int'(offd) + 1;
            if (s > m_pw + m_pd - 2) begin
               offw <= '0; offd <= '0; sh <= 1'b0;
            end else begin
               nw = (s < m_pw) ? s : m_pw - 1;
               nd = s - nw;
               offw <= 4'(nw); offd <= 4'(nd); sh <= 1'b1;
            end
         end
      end else begin
         sh <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_job(input int jpw, input int jpd, input logic [20:0] wb,
                           input logic [20:0] db, input int nt);
      int wmax, wmin, k, per;
      pair_t p;
      m_pw = jpw;
      m_pd = jpd;
      n_pairs = (jpw == 0 || jpd == 0) ? 0 : nt * jpw * jpd;
      per = jpw * jpd;
      for (int t = 0; t < nt && n_pairs > 0; t++) begin
         k = 0;
         for (int s = 0; s <= jpw + jpd - 2; s++) begin
            wmax = (s < jpw) ? s : jpw - 1;
            wmin = (s >= jpd) ? s - jpd + 1 : 0;
            for (int w = wmax; w >= wmin; w--) begin
               k++;
               p.w  = wb + 21'(t * jpw) + 21'(w);
               p.d  = db + 21'(t * jpd) + 21'(s - w);
               p.dg = (w == wmax);
               p.tl = (k == per);
               p.jl = (k == per) && (t == nt - 1);
               q.push_back(p);
            end
         end
      end
   endtask

   task automatic begin_job(input int jpw, input int jpd, input logic [20:0] wb,
                            input logic [20:0] db, input int nt);
      @(posedge clk); #1;
      pw = 4'(jpw); pd = 4'(jpd); wbase = wb; dbase = db; ntiles = 16'(nt);
      start = 1'b1;
      addr_rdy = 1'b1;
      c0 = cyc;
      push_job(jpw, jpd, wb, db, nt);
   endtask

   // mode 0: always ready; 1: stalled on relative cycles 2..4; 2: random stalls
   task automatic wait_job(input bit hold_start, input int mode);
      int rel, left, exp_done;
      bit seen;
      left = n_pairs;
      exp_done = (left == 0) ? 1 : -1;
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(posedge clk); #1;
         if (!hold_start) start = 1'b0;
         rel = cyc - c0;
         case (mode)
            0:       addr_rdy = 1'b1;
            1:       addr_rdy = !(rel >= 2 && rel <= 4);
            default: addr_rdy = ($urandom_range(0, 3) != 0);
         endcase
         if (left > 0 && addr_rdy) begin
            left--;
            if (left == 0) exp_done = rel + 1;
         end
         @(negedge clk);
         if (n_pairs == 0) begin
            check("clr_degen", 32'(clr), 32'd1);
            check("vld_degen", 32'(addr_vld), 32'd0);
         end
         if (done) begin
            check("done_cycle", rel, exp_done);
            check("busy_at_done", 32'(busy), 32'd0);
            check("queue_drained", q.size(), 32'd0);
            seen = 1;
         end
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         q.delete();
      end
   endtask

   // Scoreboard: the head pair must be presented (and held through stalls) until accepted.
   always @(negedge clk) begin
      if (rst_n) begin
         check("step", 32'(step), 32'(addr_vld & addr_rdy));
         if (addr_vld) begin
            if (q.size() == 0) begin
               check("extra_pair", 32'd1, 32'd0);
            end else begin
               check("waddr", 32'(waddr), 32'(q[0].w));
               check("daddr", 32'(daddr), 32'(q[0].d));
               check("diag",  32'(diag),  32'(q[0].dg));
               check("tlast", 32'(tlast), 32'(q[0].tl));
               check("jlast", 32'(jlast), 32'(q[0].jl));
               if (addr_rdy) void'(q.pop_front());
            end
         end
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_step"}, 32'(step), 32'd0);
      check({tag, "_clr"},  32'(clr),  32'd1);
      check({tag, "_vld"},  32'(addr_vld), 32'd0);
      check({tag, "_diag"}, 32'(diag), 32'd1);
      check({tag, "_tlast"}, 32'(tlast), 32'd0);
      check({tag, "_jlast"}, 32'(jlast), 32'd0);
      check({tag, "_addr_known"}, 32'($isunknown(waddr) | $isunknown(daddr)), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; addr_rdy = 1'b0;
      pw = '0; pd = '0; wbase = '0; dbase = '0; ntiles = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // basic single tile, then two tiles
      begin_job(2, 2, 21'd100, 21'd200, 1);
      wait_job(0, 0);
      begin_job(2, 2, 21'd100, 21'd200, 2);
      wait_job(0, 0);

      // stall on the second pair
      begin_job(2, 2, 21'd100, 21'd200, 1);
      wait_job(0, 1);

      // degenerate jobs
      begin_job(2, 0, 21'd100, 21'd200, 3);
      wait_job(0, 0);
      begin_job(0, 3, 21'd100, 21'd200, 3);
      wait_job(0, 0);
      begin_job(2, 2, 21'd100, 21'd200, 0);
      wait_job(0, 0);

      // one-pair tiles, address wrap modulo 2^21, random backpressure
      begin_job(1, 1, 21'd7, 21'd9, 3);
      wait_job(0, 0);
      begin_job(3, 2, 21'h1FFFFE, 21'h1FFFFF, 2);
      wait_job(0, 2);
      begin_job(4, 3, 21'd1000, 21'd2000, 2);
      wait_job(0, 2);

      // asynchronous reset mid-tile, then a fresh job
      begin_job(2, 2, 21'd100, 21'd200, 3);
      repeat (6) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1 check_reset_values("midrst");
      q.delete();
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      begin_job(3, 2, 21'd500, 21'd600, 1);
      wait_job(0, 0);

      // start held high: the second job begins only after a cycle back in IDLE
      begin_job(2, 3, 21'd40, 21'd80, 1);
      wait_job(1, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_idle_busy", 32'(busy), 32'd0);
      check("hold_idle_vld", 32'(addr_vld), 32'd0);
      push_job(2, 3, 21'd40, 21'd80, 1);
      c0 = cyc;
      wait_job(0, 0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
